// File: rtl/serial_drv_pkg.sv
// Shared types and defaults for the serial word driver that feeds shift_reg.
package serial_drv_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} drv_state_t;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int GAP_CYCLES_DEF = 2;

endpackage

// File: rtl/serial_word_driver.sv
// Parallel-to-serial driver: plays one accepted word out bit by bit so the
// downstream shift_reg ends up holding exactly that word.
module serial_word_driver
    import serial_drv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_lsb_first,
    output logic                  shift_en,
    output logic                  dir,
    output logic                  d_out,
    output logic                  word_done,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    drv_state_t            state, state_next;
    logic [CW-1:0]         bit_cnt, bit_cnt_next;
    logic [GW-1:0]         gap_cnt, gap_cnt_next;
    logic [DATA_WIDTH-1:0] word_q, word_next;
    logic                  lsb_q, lsb_next;
    logic                  shift_en_next;
    logic                  d_out_next;
    logic                  word_done_next;
    logic                  accept;
    logic                  last_bit;
    logic                  gap_end;

    // Bit k of the playout order: LSB-first walks up, MSB-first walks down.
    function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] w,
                                      input logic                  lsb,
                                      input logic [CW-1:0]         k);
        return lsb ? w[k] : w[BIT_LAST - k];
    endfunction

    assign accept   = (state == IDLE) && in_valid;
    assign last_bit = (state == SHIFT) && (bit_cnt == BIT_LAST);
    assign gap_end  = (state == GAP) && (gap_cnt == GAP_LAST);

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign dir      = lsb_q;

    // NOTE: state, counters, latches and outputs share one async-reset register
    // block written only with <=, so every flop updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            word_q    <= '0;
            lsb_q     <= 1'b0;
            shift_en  <= 1'b0;
            d_out     <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            gap_cnt   <= gap_cnt_next;
            word_q    <= word_next;
            lsb_q     <= lsb_next;
            shift_en  <= shift_en_next;
            d_out     <= d_out_next;
            word_done <= word_done_next;
        end
    end

    // NOTE: each combinational block assigns a default to every target first,
    // so no path can leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (accept) state_next = SHIFT;
            SHIFT: begin
                if (flush)         state_next = IDLE;
                else if (last_bit) state_next = HAS_GAP ? GAP : IDLE;
            end
            GAP:   if (flush || gap_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they line up
    // with the state they describe rather than lagging it by a cycle.
    always_comb begin
        bit_cnt_next   = bit_cnt;
        gap_cnt_next   = gap_cnt;
        word_next      = word_q;
        lsb_next       = lsb_q;
        d_out_next     = 1'b0;
        shift_en_next  = (state_next == SHIFT);
        word_done_next = last_bit && !flush;

        if (accept) begin
            word_next    = in_data;
            lsb_next     = in_lsb_first;
            bit_cnt_next = '0;
            d_out_next   = pick_bit(in_data, in_lsb_first, '0);
        end else if ((state == SHIFT) && (state_next == SHIFT)) begin
            bit_cnt_next = bit_cnt + CW'(1);
            d_out_next   = pick_bit(word_q, lsb_q, bit_cnt + CW'(1));
        end

        if ((state_next == GAP) && (state != GAP)) begin
            gap_cnt_next = '0;
        end else if (state == GAP) begin
            gap_cnt_next = gap_cnt + GW'(1);
        end
    end

endmodule

// File: tb/tb_serial_word_driver.sv
// Directed bench: serial_word_driver feeding a behavioural shift_reg model.
module tb_serial_word_driver;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_lsb_first;
    logic         shift_en;
    logic         dir;
    logic         d_out;
    logic         word_done;
    logic         busy;
    logic [W-1:0] q_out;

    int n_checks = 0;
    int n_pass   = 0;

    serial_word_driver #(.DATA_WIDTH(W), .GAP_CYCLES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_lsb_first (in_lsb_first),
        .shift_en     (shift_en),
        .dir          (dir),
        .d_out        (d_out),
        .word_done    (word_done),
        .busy         (busy)
    );

    // Downstream shift register: dir=0 shifts left (d_in enters LSB),
    // dir=1 shifts right (d_in enters MSB).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        q_out <= '0;
        else if (shift_en) q_out <= dir ? {d_out, q_out[W-1:1]} : {q_out[W-2:0], d_out};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    // Full word transfer; exp_seq holds the expected d_out bits, first bit in [7].
    task automatic run_word(input string tag, input logic [W-1:0] data, input logic lsb,
                            input logic [W-1:0] exp_seq, input logic fl);
        logic [W-1:0] seq;
        int           se_n;
        logic         dir_ok;
        @(negedge clk);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = data; in_lsb_first = lsb; flush = fl;
        @(negedge clk);
        in_valid = 1'b0; in_data = ~data; in_lsb_first = ~lsb; flush = 1'b0;
        seq = '0; se_n = 0; dir_ok = 1'b1;
        for (int k = 0; k < W; k++) begin
            seq = {seq[W-2:0], d_out};
            se_n += int'(shift_en);
            if (dir !== lsb) dir_ok = 1'b0;
            @(negedge clk);
        end
        check({tag, "_seq"},     32'(seq),       32'(exp_seq));
        check({tag, "_se_cnt"},  32'(se_n),      32'(W));
        check({tag, "_dir"},     32'(dir_ok),    32'd1);
        check({tag, "_done"},    32'(word_done), 32'd1);
        check({tag, "_q"},       32'(q_out),     32'(data));
        check({tag, "_se_off"},  32'(shift_en),  32'd0);
        @(negedge clk);
        check({tag, "_done_1c"}, 32'(word_done), 32'd0);
        check({tag, "_gap"},     32'(in_ready),  32'd0);
        @(negedge clk);
        check({tag, "_ret"},     32'(in_ready),  32'd1);
    endtask

    initial begin
        int   ready_n;
        int   done_n;
        int   se_n;
        int   wd_n;
        logic [W-1:0] q_done;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_lsb_first = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_shift_en", 32'(shift_en),  32'd0);
        check("rst_dir",      32'(dir),       32'd0);
        check("rst_d_out",    32'(d_out),     32'd0);
        check("rst_done",     32'(word_done), 32'd0);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_ready",    32'(in_ready),  32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_busy",     32'(busy),      32'd0);
        check("rel_ready",    32'(in_ready),  32'd1);

        run_word("msb_b4", 8'hB4, 1'b0, 8'b1011_0100, 1'b0);
        run_word("lsb_b4", 8'hB4, 1'b1, 8'b0010_1101, 1'b0);

        // Back-to-back with in_valid held; data is scrambled mid-word.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hA5; in_lsb_first = 1'b0;
        ready_n = 0; done_n = 0; q_done = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) in_data = 8'h00;
            if (n == 5) in_data = 8'h3C;
            if (word_done && done_n == 0) begin done_n = n; q_done = q_out; end
            if (in_ready) begin ready_n = n; break; end
        end
        check("b2b_done_cyc", 32'(done_n), 32'd9);
        check("b2b_q_a5",     32'(q_done), 32'hA5);
        check("b2b_period",   32'(ready_n), 32'd11);
        done_n = 0; q_done = '0;
        for (int m = 1; m <= 12; m++) begin
            @(negedge clk);
            if (m == 1) begin
                in_valid = 1'b0; in_data = 8'hFF;
                check("b2b_2nd_se", 32'(shift_en), 32'd1);
            end
            if (word_done && done_n == 0) begin done_n = m; q_done = q_out; end
        end
        check("b2b_done2_cyc", 32'(done_n), 32'd9);
        check("b2b_q_3c",      32'(q_done), 32'h3C);

        // Flush on the 4th shift cycle.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hFF; in_lsb_first = 1'b0;
        se_n = 0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) in_valid = 1'b0;
            se_n += int'(shift_en);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_se_cnt", 32'(se_n),     32'd4);
        check("fl_se_off", 32'(shift_en), 32'd0);
        check("fl_ready",  32'(in_ready), 32'd1);
        check("fl_busy",   32'(busy),     32'd0);
        wd_n = int'(word_done);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            wd_n += int'(word_done);
        end
        check("fl_no_done", 32'(wd_n), 32'd0);
        run_word("fl_81", 8'h81, 1'b0, 8'b1000_0001, 1'b1);

        // Asynchronous reset on the 3rd shift cycle.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hC3; in_lsb_first = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        check("ar_pre_se",  32'(shift_en), 32'd1);
        check("ar_pre_dir", 32'(dir),      32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_se",    32'(shift_en), 32'd0);
        check("ar_dir",   32'(dir),      32'd0);
        check("ar_d_out", 32'(d_out),    32'd0);
        check("ar_busy",  32'(busy),     32'd0);
        check("ar_ready", 32'(in_ready), 32'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        run_word("ar_5a", 8'h5A, 1'b0, 8'b0101_1010, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
